// File: rtl/viterbi_ber_pkg.sv
// rtl/viterbi_ber_pkg.sv - shared state type and counter width for the Viterbi BER checker
package viterbi_ber_pkg;

   localparam int CT_W = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FILL  = 2'd1,
      COUNT = 2'd2,
      DONE  = 2'd3
   } state_e;

endpackage

// File: rtl/ber_delay_line.sv
// rtl/ber_delay_line.sv - fixed-depth shift register aligning encoder input with decoder output
module ber_delay_line #(
   parameter int DEPTH = 64,
   parameter int WIDTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din_i,
   output logic [WIDTH-1:0] dout_o
);

   logic [WIDTH-1:0] stage_q [DEPTH];
   logic [WIDTH-1:0] stage_d [DEPTH];

   // next stage contents: every stage takes its predecessor, stage 0 takes the input
   always_comb begin
      stage_d[0] = din_i;
      for (int i = 1; i < DEPTH; i++) begin
         stage_d[i] = stage_q[i-1];
      end
   end

   // shift every cycle regardless of checker state; reset empties the line
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            stage_q[i] <= '0;
         end
      end else begin
         stage_q <= stage_d;
      end
   end

   assign dout_o = stage_q[DEPTH-1];

endmodule

// File: rtl/viterbi_ber_checker.sv
// rtl/viterbi_ber_checker.sv - compares delayed encoder input with Viterbi output over a bit window
module viterbi_ber_checker
   import viterbi_ber_pkg::*;
#(
   parameter int unsigned LAT     = 64,
   parameter int unsigned WIN     = 256,
   parameter int unsigned ERR_MAX = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        tx_bit_i,
   input  logic        tx_valid_i,
   input  logic        rx_bit_i,
   input  logic        start_i,
   output logic        busy_o,
   output logic        done_o,
   output logic [15:0] err_ct_o,
   output logic [15:0] bit_ct_o,
   output logic        pass_o,
   output logic        sat_o
);

   localparam logic [7:0]      LAT_LAST = 8'(LAT - 1);
   localparam logic [CT_W-1:0] WIN_LAST = CT_W'(WIN - 1);
   localparam logic [CT_W-1:0] ERR_SAT  = '1;

   state_e          state_q, state_d;
   logic [7:0]      fill_ct_q, fill_ct_d;
   logic [CT_W-1:0] err_ct_q, err_ct_d;
   logic [CT_W-1:0] bit_ct_q, bit_ct_d;
   logic            pass_q, pass_d;
   logic            sat_q, sat_d;

   logic [1:0]      dly_data;
   logic            dly_valid;
   logic            dly_bit;

   ber_delay_line #(
      .DEPTH (int'(LAT)),
      .WIDTH (2)
   ) u_delay (
      .clk    (clk),
      .rst    (rst),
      .din_i  ({tx_valid_i, tx_bit_i}),
      .dout_o (dly_data)
   );

   assign {dly_valid, dly_bit} = dly_data;

   // measurement sequencing, counting and verdict
   always_comb begin
      state_d   = state_q;
      fill_ct_d = fill_ct_q;
      err_ct_d  = err_ct_q;
      bit_ct_d  = bit_ct_q;
      pass_d    = pass_q;
      sat_d     = sat_q;
      case (state_q)
         IDLE: begin
            if (start_i) begin
               err_ct_d  = '0;
               bit_ct_d  = '0;
               sat_d     = 1'b0;
               fill_ct_d = '0;
               state_d   = FILL;
            end
         end
         FILL: begin
            // wait for the first bit sent after start to emerge from the delay line
            if (fill_ct_q == LAT_LAST) begin
               state_d = COUNT;
            end else begin
               fill_ct_d = fill_ct_q + 8'd1;
            end
         end
         COUNT: begin
            if (dly_valid) begin
               bit_ct_d = bit_ct_q + CT_W'(1);
               if (dly_bit != rx_bit_i) begin
                  if (err_ct_q == ERR_SAT) begin
                     sat_d = 1'b1;
                  end else begin
                     err_ct_d = err_ct_q + CT_W'(1);
                  end
               end
               if (bit_ct_q == WIN_LAST) begin
                  state_d = DONE;
                  pass_d  = (32'(err_ct_d) <= ERR_MAX);
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // state and counter registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         fill_ct_q <= '0;
         err_ct_q  <= '0;
         bit_ct_q  <= '0;
         pass_q    <= 1'b0;
         sat_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         fill_ct_q <= fill_ct_d;
         err_ct_q  <= err_ct_d;
         bit_ct_q  <= bit_ct_d;
         pass_q    <= pass_d;
         sat_q     <= sat_d;
      end
   end

   assign busy_o   = (state_q == FILL) || (state_q == COUNT);
   assign done_o   = (state_q == DONE);
   assign err_ct_o = err_ct_q;
   assign bit_ct_o = bit_ct_q;
   assign pass_o   = pass_q;
   assign sat_o    = sat_q;

endmodule

// File: tb/tb_viterbi_ber_checker.sv
// tb/tb_viterbi_ber_checker.sv - self-checking bench for viterbi_ber_checker
module tb_viterbi_ber_checker;

   localparam int LAT     = 4;
   localparam int WIN     = 16;
   localparam int ERR_MAX = 0;
   localparam int T_MAX   = 80;

   logic        clk = 1'b0;
   logic        rst;
   logic        tx_bit;
   logic        tx_valid;
   logic        rx_a;
   logic        start_a;
   logic        rx_b;
   logic        start_b;

   logic        busy_a, done_a, pass_a, sat_a;
   logic [15:0] err_a, bits_a;
   logic        busy_b, done_b, pass_b, sat_b;
   logic [15:0] err_b, bits_b;

   int n_asrt = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   viterbi_ber_checker #(
      .LAT(LAT), .WIN(WIN), .ERR_MAX(ERR_MAX)
   ) dut (
      .clk(clk), .rst(rst), .tx_bit_i(tx_bit), .tx_valid_i(tx_valid),
      .rx_bit_i(rx_a), .start_i(start_a), .busy_o(busy_a), .done_o(done_a),
      .err_ct_o(err_a), .bit_ct_o(bits_a), .pass_o(pass_a), .sat_o(sat_a)
   );

   viterbi_ber_checker #(
      .LAT(LAT), .WIN(65535), .ERR_MAX(ERR_MAX)
   ) dut_b (
      .clk(clk), .rst(rst), .tx_bit_i(tx_bit), .tx_valid_i(tx_valid),
      .rx_bit_i(rx_b), .start_i(start_b), .busy_o(busy_b), .done_o(done_b),
      .err_ct_o(err_b), .bit_ct_o(bits_b), .pass_o(pass_b), .sat_o(sat_b)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asrt++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      @(negedge clk);
   endtask

   // vmode 0: valid always high, 1: valid high on even cycles
   // nflip: corrupt rx on that many compared bits; abort_bits: pulse reset when bit count reaches it
   task automatic run_case(input string name, input int vmode, input int nflip,
                           input bit restarts, input int abort_bits);
      bit v  [T_MAX+1];
      bit b  [T_MAX+1];
      bit r  [T_MAX+1];
      bit st [T_MAX+1];
      int eb [T_MAX+1];
      int ee [T_MAX+1];
      int bits, errs, done_t, ndone;
      int flip_at [3];
      flip_at[0] = LAT + 3;
      flip_at[1] = LAT + 8;
      flip_at[2] = LAT + 12;

      for (int t = 0; t <= T_MAX; t++) begin
         v[t]  = (vmode == 0) ? 1'b1 : (t % 2 == 0);
         b[t]  = 1'($urandom_range(0, 1));
         st[t] = (t == 0) || (restarts && (t == 2 || t == 12));
      end
      for (int t = 0; t <= T_MAX; t++) begin
         r[t] = (t >= LAT) ? b[t-LAT] : 1'($urandom_range(0, 1));
      end
      for (int k = 0; k < nflip; k++) begin
         r[flip_at[k]] = ~r[flip_at[k]];
      end

      // reference: first compare LAT+1 edges after start, using the bit sent LAT edges earlier
      bits   = 0;
      errs   = 0;
      done_t = -1;
      for (int t = 0; t <= T_MAX; t++) begin
         if (done_t < 0 && t > LAT) begin
            if (v[t-LAT]) begin
               bits++;
               if (b[t-LAT] != r[t]) errs++;
            end
            if (bits == WIN) done_t = t;
         end
         eb[t] = bits;
         ee[t] = errs;
      end

      ndone = 0;
      for (int t = 0; t <= done_t + 2; t++) begin
         tx_valid = v[t];
         tx_bit   = b[t];
         rx_a     = r[t];
         start_a  = st[t];
         next_cycle();
         start_a  = 1'b0;
         if (done_a) ndone++;
         chk({name, " busy"}, busy_a, (t < done_t));
         chk({name, " done"}, done_a, (t == done_t));
         chk({name, " bit_ct"}, bits_a, eb[t]);
         chk({name, " err_ct"}, err_a, ee[t]);
         chk({name, " sat"}, sat_a, 1'b0);
         if (t >= done_t) chk({name, " pass"}, pass_a, (ee[done_t] <= ERR_MAX));
         if (abort_bits > 0 && eb[t] == abort_bits) begin
            rst = 1'b0;
            #1;
            chk({name, " rst busy"}, busy_a, 1'b0);
            chk({name, " rst done"}, done_a, 1'b0);
            chk({name, " rst err"}, err_a, 16'h0);
            chk({name, " rst bits"}, bits_a, 16'h0);
            chk({name, " rst pass"}, pass_a, 1'b0);
            chk({name, " rst sat"}, sat_a, 1'b0);
            @(negedge clk);
            rst = 1'b1;
            ndone = 0;
            for (int k = 0; k < 30; k++) begin
               tx_bit = 1'($urandom_range(0, 1));
               rx_a   = 1'($urandom_range(0, 1));
               next_cycle();
               if (done_a) ndone++;
               chk({name, " idle busy"}, busy_a, 1'b0);
            end
            chk({name, " no done after reset"}, ndone, 0);
            return;
         end
      end
      chk({name, " done pulses"}, ndone, 1);
   endtask

   initial begin
      logic [15:0] exp_e;
      logic        exp_s;

      rst      = 1'b0;
      tx_bit   = 1'b0;
      tx_valid = 1'b0;
      rx_a     = 1'b0;
      start_a  = 1'b0;
      rx_b     = 1'b0;
      start_b  = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset busy", busy_a, 1'b0);
      chk("reset done", done_a, 1'b0);
      chk("reset err", err_a, 16'h0);
      chk("reset bits", bits_a, 16'h0);
      chk("reset pass", pass_a, 1'b0);
      chk("reset sat", sat_a, 1'b0);
      rst = 1'b1;
      next_cycle();

      run_case("clean", 0, 0, 1'b0, 0);
      run_case("flip3", 0, 3, 1'b0, 0);
      chk("flip3 final err", err_a, 16'd3);
      run_case("toggle", 1, 0, 1'b0, 0);
      run_case("abort", 0, 0, 1'b0, 7);
      run_case("after_abort", 0, 2, 1'b0, 0);
      run_case("restart", 0, 0, 1'b1, 0);

      // saturation: every compared bit mismatches, counter preloaded near full scale
      tx_valid = 1'b1;
      tx_bit   = 1'b0;
      rx_b     = 1'b1;
      start_b  = 1'b1;
      next_cycle();
      start_b  = 1'b0;
      for (int k = 1; k <= LAT + 2; k++) next_cycle();
      chk("sat pre err", err_b, 16'd2);
      force dut_b.err_ct_q = 16'hFFFE;
      #1;
      release dut_b.err_ct_q;
      chk("sat preload", err_b, 16'hFFFE);
      exp_e = 16'hFFFE;
      exp_s = 1'b0;
      for (int k = 0; k < 3; k++) begin
         next_cycle();
         if (exp_e == 16'hFFFF) exp_s = 1'b1;
         else exp_e = exp_e + 16'd1;
         chk("sat err", err_b, exp_e);
         chk("sat flag", sat_b, exp_s);
         chk("sat busy", busy_b, 1'b1);
      end
      chk("sat bits", bits_b, 16'd5);
      rst = 1'b0;
      #1;
      chk("sat cleared by reset", sat_b, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      next_cycle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
      $finish;
   end

endmodule
